// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the UART receive path.
// Provides rx_state_t, data-bit encodings and the rx_entry_t FIFO record.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    // Index of the last data bit for a given cfg_dbits encoding (4..7).
    function automatic logic [2:0] dbits_last(input logic [1:0] dbits);
        return 3'd4 + {1'b0, dbits};
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through FIFO with level and drop indication.
// Ports: clk_i, reset_i, push_i, pop_i, wdata_i -> rdata_o (head), lvl_o,
//        full_o, empty_o, drop_o (push refused because full without pop).
module uart_fifo #(
    parameter  int WIDTH = 11,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LW-1:0]    lvl_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (lvl_q == LW'(DEPTH));
    assign empty_o = (lvl_q == '0);
    assign lvl_o   = lvl_q;
    assign rdata_o = mem_q[rd_q];

    always_comb begin
        do_pop  = pop_i & ~empty_o;
        // A pop in the same cycle frees the slot a full FIFO needs.
        do_push = push_i & (~full_o | do_pop);
        drop_o  = push_i & ~do_push;
        wr_d    = wr_q;
        rd_d    = rd_q;
        lvl_d   = lvl_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampled UART receiver (5-8N/E/O 1/2) with tagged RX FIFO.
// In: clk_i, reset_i, osr_tick_i, rx_data_i, rx_en_i, cfg_*, FIFO pop/clear,
//     rx_thresh_i. Out: busy, overrun, level/valid/head data+flags, threshold,
//     timeout. Define UART_RX_TIMEOUT_EN to build the character-timeout counter.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter  int OSR          = 16,
    parameter  int FIFO_DEPTH   = 16,
    parameter  int TIMEOUT_BITS = 40,
    localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             osr_tick_i,
    input  logic             rx_data_i,
    input  logic             rx_en_i,
    input  logic [1:0]       cfg_dbits_i,
    input  logic             cfg_par_en_i,
    input  logic             cfg_par_odd_i,
    input  logic             cfg_stop2_i,
    input  logic             rx_fifo_ren_i,
    input  logic             rx_clr_ovrn_i,
    input  logic [LVL_W-1:0] rx_thresh_i,
    output logic             rx_busy_o,
    output logic             rx_ovrn_o,
    output logic [LVL_W-1:0] rx_lvl_o,
    output logic             rx_valid_o,
    output logic [7:0]       rx_data_o,
    output logic             rx_perr_o,
    output logic             rx_ferr_o,
    output logic             rx_brk_o,
    output logic             rx_thresh_o,
    output logic             rx_timeout_o
);

    localparam int TICK_W = $clog2(OSR);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OSR - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OSR / 2 - 1);

    logic              sync1_q, sync2_q;
    logic              rx_s;
    rx_state_t         state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        data_q, data_d;
    logic              par_q, par_d;
    logic              ferr_q, ferr_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              armed_q, armed_d;
    logic [1:0]        dbits_q, dbits_d;
    logic              par_en_q, par_en_d;
    logic              par_odd_q, par_odd_d;
    logic              stop2_q, stop2_d;
    logic              ovrn_q, ovrn_d;
    logic              push;
    logic              frame_ferr;
    rx_entry_t         push_entry;
    rx_entry_t         head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;

    assign rx_s = sync2_q;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        stop_cnt_d = stop_cnt_q;
        armed_d    = armed_q;
        dbits_d    = dbits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        push       = 1'b0;

        // Entry fields fold in the stop sample taken on the push cycle.
        frame_ferr      = ferr_q | ~rx_s;
        push_entry.data = data_q;
        push_entry.perr = par_en_q & ((^data_q ^ par_q) != par_odd_q);
        push_entry.ferr = frame_ferr;
        push_entry.brk  = (data_q == 8'h00) & (~par_en_q | ~par_q)
                        & frame_ferr;

        unique case (state_q)
            IDLE: begin
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q && osr_tick_i) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    data_d     = '0;
                    par_d      = 1'b0;
                    ferr_d     = 1'b0;
                    dbits_d    = cfg_dbits_i;
                    par_en_d   = cfg_par_en_i;
                    par_odd_d  = cfg_par_odd_i;
                    stop2_d    = cfg_stop2_i;
                end
            end
            START: begin
                if (osr_tick_i) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (osr_tick_i) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d        = '0;
                        data_d[bit_cnt_q] = rx_s;
                        bit_cnt_d         = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == dbits_last(dbits_q)) begin
                            stop_cnt_d = 1'b0;
                            state_d    = par_en_q ? PARITY : STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (osr_tick_i) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        par_d      = rx_s;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (osr_tick_i) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        ferr_d     = frame_ferr;
                        if (stop_cnt_q == stop2_q) begin
                            // Disarm so a held-low line cannot retrigger.
                            push    = 1'b1;
                            armed_d = 1'b0;
                            state_d = IDLE;
                        end else begin
                            stop_cnt_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rx_en_i) begin
            state_d = IDLE;
            armed_d = 1'b0;
            push    = 1'b0;
        end
    end

    always_comb begin
        ovrn_d = ovrn_q;
        if (fifo_drop) begin
            ovrn_d = 1'b1;
        end else if (rx_clr_ovrn_i) begin
            ovrn_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
            stop_cnt_q <= 1'b0;
            armed_q    <= 1'b0;
            dbits_q    <= DBITS_8;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            ovrn_q     <= 1'b0;
        end else begin
            sync1_q    <= rx_data_i;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_q      <= par_d;
            ferr_q     <= ferr_d;
            stop_cnt_q <= stop_cnt_d;
            armed_q    <= armed_d;
            dbits_q    <= dbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            ovrn_q     <= ovrn_d;
        end
    end

    uart_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (rx_fifo_ren_i),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .lvl_o   (rx_lvl_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    // Head fields are masked so an empty FIFO presents all zeros.
    assign rx_valid_o  = ~fifo_empty;
    assign rx_data_o   = rx_valid_o ? head_entry.data : 8'h00;
    assign rx_perr_o   = rx_valid_o & head_entry.perr;
    assign rx_ferr_o   = rx_valid_o & head_entry.ferr;
    assign rx_brk_o    = rx_valid_o & head_entry.brk;
    assign rx_busy_o   = (state_q != IDLE);
    assign rx_ovrn_o   = ovrn_q;
    assign rx_thresh_o = (rx_thresh_i != '0) && (rx_lvl_o >= rx_thresh_i);

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_BITS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_BITS - 1);

    logic [TICK_W-1:0] to_tick_q, to_tick_d;
    logic [TO_W-1:0]   to_bits_q, to_bits_d;
    logic              timeout_q, timeout_d;

    always_comb begin
        to_tick_d = to_tick_q;
        to_bits_d = to_bits_q;
        timeout_d = timeout_q;
        if (push || (rx_fifo_ren_i && rx_valid_o)) begin
            to_tick_d = '0;
            to_bits_d = '0;
            timeout_d = 1'b0;
        end else if (state_q == IDLE && rx_valid_o && osr_tick_i
                     && !timeout_q) begin
            if (to_tick_q == TICK_LAST) begin
                to_tick_d = '0;
                to_bits_d = to_bits_q + 1'b1;
                if (to_bits_q == TO_LAST) begin
                    timeout_d = 1'b1;
                end
            end else begin
                to_tick_d = to_tick_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            to_tick_q <= '0;
            to_bits_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_tick_q <= to_tick_d;
            to_bits_q <= to_bits_d;
            timeout_q <= timeout_d;
        end
    end

    assign rx_timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_BITS;
    assign rx_timeout_o       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed self-checking bench for uart_rx_ext.
// Drives serial frames at OSR=16 with a tick every TDIV clocks.
module tb_uart_rx_ext;

    localparam int OSR   = 16;
    localparam int LVL_W = 5;
    localparam int TDIV  = 2;
    localparam int BIT   = OSR * TDIV;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             osr_tick_i;
    logic             rx_data_i;
    logic             rx_en_i;
    logic [1:0]       cfg_dbits_i;
    logic             cfg_par_en_i;
    logic             cfg_par_odd_i;
    logic             cfg_stop2_i;
    logic             rx_fifo_ren_i;
    logic             rx_clr_ovrn_i;
    logic [LVL_W-1:0] rx_thresh_i;
    logic             rx_busy_o;
    logic             rx_ovrn_o;
    logic [LVL_W-1:0] rx_lvl_o;
    logic             rx_valid_o;
    logic [7:0]       rx_data_o;
    logic             rx_perr_o;
    logic             rx_ferr_o;
    logic             rx_brk_o;
    logic             rx_thresh_o;
    logic             rx_timeout_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int rise_cyc  = 0;
    bit vprev     = 1'b0;
    bit thr_mon   = 1'b0;
    int thr_bad   = 0;

    uart_rx_ext #(
        .OSR          (OSR),
        .FIFO_DEPTH   (16),
        .TIMEOUT_BITS (40)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .osr_tick_i    (osr_tick_i),
        .rx_data_i     (rx_data_i),
        .rx_en_i       (rx_en_i),
        .cfg_dbits_i   (cfg_dbits_i),
        .cfg_par_en_i  (cfg_par_en_i),
        .cfg_par_odd_i (cfg_par_odd_i),
        .cfg_stop2_i   (cfg_stop2_i),
        .rx_fifo_ren_i (rx_fifo_ren_i),
        .rx_clr_ovrn_i (rx_clr_ovrn_i),
        .rx_thresh_i   (rx_thresh_i),
        .rx_busy_o     (rx_busy_o),
        .rx_ovrn_o     (rx_ovrn_o),
        .rx_lvl_o      (rx_lvl_o),
        .rx_valid_o    (rx_valid_o),
        .rx_data_o     (rx_data_o),
        .rx_perr_o     (rx_perr_o),
        .rx_ferr_o     (rx_ferr_o),
        .rx_brk_o      (rx_brk_o),
        .rx_thresh_o   (rx_thresh_o),
        .rx_timeout_o  (rx_timeout_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        osr_tick_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            osr_tick_i = (cyc % TDIV == 0);
        end
    end

    always @(negedge clk) begin
        if (rx_valid_o && !vprev) rise_cyc = cyc;
        vprev = rx_valid_o;
        if (thr_mon && (rx_thresh_o !== (rx_lvl_o >= 5'd4))) thr_bad++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n, input bit pop_en);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (pop_en) rx_fifo_ren_i = dut.push;
        end
    endtask

    task automatic send_char(input logic [7:0] d, input int nb,
                             input bit pen, input bit pb,
                             input bit s1, input bit s2, input int ns,
                             input bit pop_en);
        @(negedge clk);
        rx_data_i = 1'b0;
        start_cyc = cyc;
        hold(BIT, pop_en);
        for (int i = 0; i < nb; i++) begin
            rx_data_i = d[i];
            hold(BIT, pop_en);
        end
        if (pen) begin
            rx_data_i = pb;
            hold(BIT, pop_en);
        end
        rx_data_i = s1;
        hold(BIT, pop_en);
        if (ns == 2) begin
            rx_data_i = s2;
            hold(BIT, pop_en);
        end
        rx_data_i = 1'b1;
        hold(BIT, pop_en);
        rx_fifo_ren_i = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        rx_fifo_ren_i = 1'b1;
        @(negedge clk);
        rx_fifo_ren_i = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] db, input bit pen, input bit podd,
                       input bit s2);
        cfg_dbits_i   = db;
        cfg_par_en_i  = pen;
        cfg_par_odd_i = podd;
        cfg_stop2_i   = s2;
    endtask

    initial begin
        int lat;
        logic [7:0] exp_d;
        reset_i       = 1'b1;
        rx_data_i     = 1'b1;
        rx_en_i       = 1'b1;
        rx_fifo_ren_i = 1'b0;
        rx_clr_ovrn_i = 1'b0;
        rx_thresh_i   = '0;
        cfg(2'd3, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_lvl", rx_lvl_o, 0);
        check("rst_valid", rx_valid_o, 0);
        check("rst_busy", rx_busy_o, 0);
        check("rst_ovrn", rx_ovrn_o, 0);
        check("rst_data", rx_data_o, 0);
        check("rst_flags", {rx_perr_o, rx_ferr_o, rx_brk_o}, 0);
        check("rst_thresh", rx_thresh_o, 0);
        check("rst_timeout", rx_timeout_o, 0);
        repeat (BIT) @(negedge clk);

        // 8N1 0xA5
        send_char(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        lat = rise_cyc - start_cyc;
        check("a5_latency", (lat >= 9 * BIT && lat <= 10 * BIT), 1);
        check("a5_lvl", rx_lvl_o, 1);
        check("a5_data", rx_data_o, 8'hA5);
        check("a5_flags", {rx_perr_o, rx_ferr_o, rx_brk_o}, 0);
        pop();
        check("a5_pop_lvl", rx_lvl_o, 0);
        check("a5_pop_valid", rx_valid_o, 0);

        // 7E1 0x41 with wrong parity bit 1
        cfg(2'd2, 1'b1, 1'b0, 1'b0);
        send_char(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        check("7e1_data", rx_data_o, 8'h41);
        check("7e1_perr", rx_perr_o, 1);
        check("7e1_ferr", rx_ferr_o, 0);
        pop();

        // 5O2 0x15, correct parity 0, second stop low
        cfg(2'd0, 1'b1, 1'b1, 1'b1);
        send_char(8'h15, 5, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        check("5o2_data", rx_data_o, 8'h15);
        check("5o2_flags", {rx_perr_o, rx_ferr_o, rx_brk_o}, 3'b010);
        pop();

        // False start: 6 ticks low
        cfg(2'd3, 1'b0, 1'b0, 1'b0);
        repeat (BIT) @(negedge clk);
        rx_data_i = 1'b0;
        repeat (8) @(negedge clk);
        check("fs_busy_hi", rx_busy_o, 1);
        repeat (6 * TDIV - 8) @(negedge clk);
        rx_data_i = 1'b1;
        repeat (20 * TDIV) @(negedge clk);
        check("fs_busy_lo", rx_busy_o, 0);
        check("fs_lvl", rx_lvl_o, 0);

        // Break: line low for two frames
        rx_data_i = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        rx_data_i = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("brk_lvl", rx_lvl_o, 1);
        check("brk_data", rx_data_o, 0);
        check("brk_flags", {rx_perr_o, rx_ferr_o, rx_brk_o}, 3'b011);
        pop();

        // rx_en_i dropped mid-frame
        rx_data_i = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        check("en_busy_hi", rx_busy_o, 1);
        rx_en_i = 1'b0;
        @(negedge clk);
        check("en_busy_lo", rx_busy_o, 0);
        rx_data_i = 1'b1;
        repeat (BIT) @(negedge clk);
        rx_en_i = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        check("en_lvl", rx_lvl_o, 0);
        check("en_busy_idle", rx_busy_o, 0);

        // Threshold 4
        rx_thresh_i = 5'd4;
        thr_mon = 1'b1;
        for (int i = 0; i < 3; i++)
            send_char(8'h10 + 8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        check("thr_lvl3", rx_lvl_o, 3);
        check("thr_lo", rx_thresh_o, 0);
        send_char(8'h13, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        check("thr_lvl4", rx_lvl_o, 4);
        check("thr_hi", rx_thresh_o, 1);
        thr_mon = 1'b0;
        check("thr_track", thr_bad, 0);
        rx_thresh_i = '0;

        // Fill to 17 characters total
        for (int i = 4; i < 17; i++)
            send_char(8'h10 + 8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        check("ovf_lvl", rx_lvl_o, 16);
        check("ovf_ovrn", rx_ovrn_o, 1);
        check("ovf_head", rx_data_o, 8'h10);
        @(negedge clk);
        rx_clr_ovrn_i = 1'b1;
        @(negedge clk);
        rx_clr_ovrn_i = 1'b0;
        check("ovf_clr", rx_ovrn_o, 0);

        // Pop coincident with push while full
        send_char(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        check("pp_lvl", rx_lvl_o, 16);
        check("pp_ovrn", rx_ovrn_o, 0);
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 15) ? 8'h11 + 8'(i) : 8'h55;
            check("drain_data", rx_data_o, exp_d);
            pop();
        end
        check("drain_valid", rx_valid_o, 0);
        check("drain_lvl", rx_lvl_o, 0);

        // Character timeout
        send_char(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        check("to_data", rx_data_o, 8'h3C);
        check("to_early", rx_timeout_o, 0);
        repeat (45 * BIT) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
        check("to_set", rx_timeout_o, 1);
`else
        check("to_off", rx_timeout_o, 0);
`endif
        pop();
        check("to_clr", rx_timeout_o, 0);
        check("to_lvl", rx_lvl_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
